// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared constants, state encoding and helpers for the dynamic seven-segment driver
package smg_pkg;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } cvt_state_t;

  // ceil(dw * log10(2)) + 1 nibbles; the spare nibble keeps the top of the
  // accumulator clear so the final left shift never loses a digit
  function automatic int bcd_nibbles(input int dw);
    return (dw * 30103 + 99999) / 100000 + 1;
  endfunction

  // Largest value representable on n decimal digits
  function automatic int pow10_minus1(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r - 1;
  endfunction

  // BCD nibble to active-high segments; codes above 9 cannot occur and show blank
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/smg_dynamic_multi_bin2bcd_seq.sv
// rtl/smg_dynamic_multi_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter with valid/busy handshake
module bin2bcd_seq
  import smg_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int DIG_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_vld,
  input  logic [DIG_NUM-1:0]     dp_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIG_NUM-1:0]   bcd_res,
  output logic [DIG_NUM-1:0]     dp_res,
  output logic                   ovf_res
);

  localparam int NIB     = bcd_nibbles(DATA_W);
  localparam int BW      = 4 * NIB;
  localparam int RW      = 4 * ((NIB > DIG_NUM) ? NIB : DIG_NUM);
  localparam int CW      = $clog2(DATA_W + 1);
  localparam int OVF_LIM = pow10_minus1(DIG_NUM);

  cvt_state_t          state, state_nxt;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_nxt;
  logic [RW-1:0]       bcd_pad;
  logic [DIG_NUM-1:0]  dp_hold;
  logic                ovf_hold;
  logic                ovf_cmp;
  logic                last_bit;
  logic                accept;

  assign last_bit = (bit_cnt == CW'(DATA_W - 1));
  assign accept   = (state == ST_IDLE) && data_vld;
  assign ovf_cmp  = (32'(data_in) > 32'(OVF_LIM));

  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: one SHIFT cycle per input bit, then back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (data_vld) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_SHIFT) && last_bit;
  end

  // Add 3 to every nibble >= 5, then shift the next binary bit in
  always_comb begin
    bcd_adj = '0;
    for (int n = 0; n < NIB; n++) begin
      bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
    bcd_nxt = {bcd_adj[BW-2:0], shreg[DATA_W-1]};
    bcd_pad = RW'(bcd_nxt);
  end

  // Conversion datapath: load on accept, shift while converting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      dp_hold  <= '0;
      ovf_hold <= 1'b0;
    end else if (accept) begin
      shreg    <= data_in;
      bcd      <= '0;
      bit_cnt  <= '0;
      dp_hold  <= dp_in;
      ovf_hold <= ovf_cmp;
    end else if (state == ST_SHIFT) begin
      shreg    <= shreg << 1;
      bcd      <= bcd_nxt;
      bit_cnt  <= bit_cnt + 1'b1;
    end
  end

  // Result is taken from the shift that is about to happen, valid when done=1
  assign bcd_res = bcd_pad[4*DIG_NUM-1:0];
  assign dp_res  = dp_hold;
  assign ovf_res = ovf_hold;

endmodule

// File: rtl/smg_dynamic_multi.sv
// rtl/smg_dynamic_multi.sv - multiplexed seven-segment driver with sequential BCD, blanking and overflow
module smg_dynamic_multi
  import smg_pkg::*;
#(
  parameter int DIG_NUM      = 4,
  parameter int DATA_W       = 14,
  parameter int CNT_SCAN_MAX = 49_999,
  parameter int LZ_BLANK     = 1,
  parameter int SEG_ACT_LOW  = 1,
  parameter int BIT_ACT_LOW  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_vld,
  input  logic [DIG_NUM-1:0] dp_in,
  output logic               busy,
  output logic [DIG_NUM-1:0] led_bit,
  output logic [7:0]         led_out
);

  localparam int SCAN_W = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;
  localparam int IDX_W  = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam logic [DIG_NUM-1:0] BIT_POL = (BIT_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0]         SEG_POL = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic                  done;
  logic [4*DIG_NUM-1:0]  bcd_res;
  logic [DIG_NUM-1:0]    dp_res;
  logic                  ovf_res;

  logic [4*DIG_NUM-1:0]  disp_val, disp_val_nxt;
  logic [DIG_NUM-1:0]    disp_dp, disp_dp_nxt;
  logic                  disp_ovf, disp_ovf_nxt;

  logic [SCAN_W-1:0]     scan_cnt;
  logic                  scan_wrap;
  logic [IDX_W-1:0]      dig_idx, dig_idx_adv;
  logic [DIG_NUM-1:0]    upper_zero;
  logic [DIG_NUM-1:0]    bit_nxt, bit_q;
  logic [7:0]            seg_nxt, seg_q;

  bin2bcd_seq #(
    .DATA_W  (DATA_W),
    .DIG_NUM (DIG_NUM)
  ) u_bin2bcd (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .data_in  (data_in),
    .data_vld (data_vld),
    .dp_in    (dp_in),
    .busy     (busy),
    .done     (done),
    .bcd_res  (bcd_res),
    .dp_res   (dp_res),
    .ovf_res  (ovf_res)
  );

  // Value the display register holds after this edge; lets a slot starting
  // on the completion edge show the fresh result
  always_comb begin
    disp_val_nxt = done ? bcd_res : disp_val;
    disp_dp_nxt  = done ? dp_res  : disp_dp;
    disp_ovf_nxt = done ? ovf_res : disp_ovf;
  end

  // Display register, updated only when a conversion completes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      disp_ovf <= 1'b0;
    end else if (done) begin
      disp_val <= bcd_res;
      disp_dp  <= dp_res;
      disp_ovf <= ovf_res;
    end
  end

  // Leading-zero map: bit i set when nibbles i..DIG_NUM-1 are all zero
  always_comb begin
    upper_zero = '0;
    upper_zero[DIG_NUM-1] = (disp_val_nxt[4*(DIG_NUM-1) +: 4] == 4'd0);
    for (int i = DIG_NUM - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp_val_nxt[4*i +: 4] == 4'd0);
    end
  end

  // Active-high select and segments for the digit dig_idx points at
  always_comb begin
    bit_nxt = '0;
    seg_nxt = {1'b0, SEG_BLANK};
    for (int i = 0; i < DIG_NUM; i++) begin
      if (IDX_W'(i) == dig_idx) begin
        bit_nxt[i] = 1'b1;
        if (disp_ovf_nxt)
          seg_nxt = {1'b0, SEG_MINUS};
        else if ((LZ_BLANK != 0) && (i > 0) && upper_zero[i])
          seg_nxt = {disp_dp_nxt[i], SEG_BLANK};
        else
          seg_nxt = {disp_dp_nxt[i], seg_decode(disp_val_nxt[4*i +: 4])};
      end
    end
  end

  assign scan_wrap   = (scan_cnt == SCAN_W'(CNT_SCAN_MAX));
  assign dig_idx_adv = (dig_idx == IDX_W'(DIG_NUM - 1)) ? '0 : dig_idx + 1'b1;

  // Slot timer; at each wrap drive digit dig_idx and move the pointer on,
  // so digit 0 is the first one lit after reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      bit_q    <= '0;
      seg_q    <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx_adv;
      bit_q    <= bit_nxt;
      seg_q    <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign led_bit = bit_q ^ BIT_POL;
  assign led_out = seg_q ^ SEG_POL;

endmodule
